fir_out_decimator: RTL and testbench

//  Downstream stage of the FIR filter. Takes the FIR's signed fixed-point output stream (data_out/out_valid).

---
 rtl/fir_out_decimator.sv | 182 ++++++++++++++++++
 tb/tb_fir_out_decimator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decimator.sv
// ---------------------------------------------------------------------------
// fir_out_decimator
//   Output stage placed after the FIR filter. Keeps one of every DECIM valid
//   samples, rounds (half up) and saturates it to the output word format,
//   then queues it in a small show-ahead FIFO with a valid/ready handshake.
//   The FIR cannot be stalled, so a full FIFO drops the sample and raises a
//   sticky overflow flag instead of back-pressuring.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   data_in    in   signed fixed-point sample [IN_INTE_WL-1:-IN_FRAC_WL]
//   in_valid   in   data_in valid
//   data_out   out  signed requantised head entry [OUT_INTE_WL-1:-OUT_FRAC_WL]
//   out_valid  out  FIFO non-empty, data_out is the head entry
//   out_ready  in   consumer takes the head when out_valid & out_ready
//   sat        out  pulse: the entry written to the FIFO this cycle was saturated
//   overflow   out  sticky: a sample was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module fir_out_decimator #(
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 6,
  parameter int DECIM       = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL]   data_in,
  input  logic                                    in_valid,
  output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    sat,
  output logic                                    overflow
);

  localparam int IW  = IN_INTE_WL + IN_FRAC_WL;
  localparam int OW  = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int SH  = IN_FRAC_WL - OUT_FRAC_WL;
  localparam int LSH = (SH < 0) ? -SH : 0;
  // Working width: holds the left-shifted input or the output range, plus one
  // guard bit so the rounding carry can never wrap.
  localparam int XW  = ((IW + LSH) > OW) ? (IW + LSH) : OW;
  localparam int WW  = XW + 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PW-1:0] PH_ONE    = PW'(1'b1);
  localparam logic [PW-1:0] PH_LAST   = PW'(DECIM - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [WW-1:0] MAX_U     = {{(WW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic [WW-1:0] MIN_U     = {{(WW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  logic [PW-1:0]        phase_r;
  logic                 stage_valid_r;
  logic [OW-1:0]        stage_data_r;
  logic                 stage_sat_r;
  logic [OW-1:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          count_r;

  logic                 keep_s;
  logic signed [WW-1:0] in_ext_s;
  logic signed [WW-1:0] rnd_s;
  logic [OW-1:0]        q_s;
  logic                 q_sat_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 wr_en_s;
  logic                 drop_s;
  logic [AW:0]          count_nxt_s;
  logic [OW-1:0]        head_nxt_s;

  assign in_ext_s = {{(WW - IW){data_in[IN_INTE_WL-1]}}, data_in};

  generate
    if (SH > 0) begin : g_round
      localparam logic [WW-1:0] HALF = WW'(1'b1) << (SH - 1);
      logic signed [WW-1:0] sum_s;
      assign sum_s = in_ext_s + $signed(HALF);
      assign rnd_s = sum_s >>> SH;
    end else begin : g_lshift
      assign rnd_s = in_ext_s <<< LSH;
    end
  endgenerate

  // Decimation keep decision and saturation of the rounded value
  always_comb begin
    keep_s = in_valid & (phase_r == '0);
    if (rnd_s > $signed(MAX_U)) begin
      q_s     = MAX_U[OW-1:0];
      q_sat_s = 1'b1;
    end else if (rnd_s < $signed(MIN_U)) begin
      q_s     = MIN_U[OW-1:0];
      q_sat_s = 1'b1;
    end else begin
      q_s     = rnd_s[OW-1:0];
      q_sat_s = 1'b0;
    end
  end

  // FIFO handshake decode, next occupancy and next head entry
  always_comb begin
    pop_s   = out_valid & out_ready;
    full_s  = (count_r == CNT_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_en_s = stage_valid_r & (~full_s | pop_s);
    drop_s  = stage_valid_r & full_s & ~pop_s;
    sat     = stage_valid_r & stage_sat_r & wr_en_s;
    if (pop_s) begin
      if (count_r == CNT_ONE) begin
        if (wr_en_s) begin
          head_nxt_s = stage_data_r;
        end else begin
          head_nxt_s = data_out;
        end
      end else begin
        head_nxt_s = mem_r[rd_ptr_r + PTR_ONE];
      end
    end else if (wr_en_s && (count_r == CNT_ZERO)) begin
      head_nxt_s = stage_data_r;
    end else begin
      head_nxt_s = data_out;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage write (contents need no reset, occupancy guards reads)
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[wr_ptr_r] <= stage_data_r;
    end
  end

  // Phase counter, stage register, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r       <= '0;
      stage_valid_r <= 1'b0;
      stage_data_r  <= '0;
      stage_sat_r   <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      data_out      <= '0;
      out_valid     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (in_valid) begin
        phase_r <= (phase_r == PH_LAST) ? '0 : phase_r + PH_ONE;
      end
      stage_valid_r <= keep_s;
      if (keep_s) begin
        stage_data_r <= q_s;
        stage_sat_r  <= q_sat_s;
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r   <= count_nxt_s;
      out_valid <= (count_nxt_s != CNT_ZERO);
      data_out  <= head_nxt_s;
      if (drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_decimator.sv
// ---------------------------------------------------------------------------
// tb_fir_out_decimator
//   Directed bench with two instances: DECIM=4 (ramp, mid-stream reset) and
//   DECIM=1 (rounding, saturation, backpressure, full push/pop).
//   Inputs change 1 time unit after the rising edge; outputs are sampled one
//   more unit later, so each observation belongs to the cycle being driven.
// ---------------------------------------------------------------------------
module tb_fir_out_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst4, v4, r4, ov4, sat4, of4;
  logic signed [11:0] d4;
  logic signed [9:0]  o4;
  logic              rst1, v1, r1, ov1, sat1, of1;
  logic signed [11:0] d1;
  logic signed [9:0]  o1;

  fir_out_decimator #(.IN_INTE_WL(4), .IN_FRAC_WL(8), .OUT_INTE_WL(4), .OUT_FRAC_WL(6),
                      .DECIM(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .data_in(d4), .in_valid(v4), .data_out(o4),
    .out_valid(ov4), .out_ready(r4), .sat(sat4), .overflow(of4));

  fir_out_decimator #(.IN_INTE_WL(4), .IN_FRAC_WL(8), .OUT_INTE_WL(4), .OUT_FRAC_WL(6),
                      .DECIM(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst1), .data_in(d1), .in_valid(v1), .data_out(o1),
    .out_valid(ov1), .out_ready(r1), .sat(sat1), .overflow(of1));

  int total = 0;
  int bad   = 0;
  logic signed [9:0] got[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] qget(input int j);
    if (j < got.size()) return got[j];
    else return 32'bx;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int vec2[5]  = '{3, 2, 1, -2, -3};
  int exp2[5]  = '{1, 1, 0, 0, -1};
  int vec4[6]  = '{10, 20, 30, 40, 2047, 60};
  int exp4[4]  = '{3, 5, 8, 10};
  int vec6[6]  = '{40, 1, 1, 1, 80, 1};
  int satcnt;

  initial begin
    rst4 = 1'b1; v4 = 1'b0; d4 = '0; r4 = 1'b0;
    rst1 = 1'b1; v1 = 1'b0; d1 = '0; r1 = 1'b0;
    cyc(); cyc();
    rst4 = 1'b0; rst1 = 1'b0;
    #1;
    check("rst_out_valid4", ov4, 0);
    check("rst_data_out4", o4, 0);
    check("rst_sat4", sat4, 0);
    check("rst_overflow4", of4, 0);
    check("rst_out_valid1", ov1, 0);
    check("rst_overflow1", of1, 0);

    // 1. Ramp 0..15 through DECIM=4, consumer always ready
    r4 = 1'b1;
    got.delete();
    satcnt = 0;
    for (int i = 0; i < 24; i++) begin
      v4 = (i < 16);
      d4 = 12'(i);
      #1;
      if (i == 1) check("t1_not_yet_valid", ov4, 0);
      if (i == 2) check("t1_first_valid", ov4, 1);
      if (sat4) satcnt++;
      if (ov4 && r4) got.push_back(o4);
      cyc();
    end
    check("t1_count", got.size(), 4);
    for (int j = 0; j < 4; j++) check($sformatf("t1_out%0d", j), qget(j), j);
    check("t1_idle", ov4, 0);
    check("t1_no_sat", satcnt, 0);

    // 2. Rounding, DECIM=1
    r1 = 1'b1;
    got.delete();
    satcnt = 0;
    for (int i = 0; i < 10; i++) begin
      v1 = (i < 5);
      d1 = (i < 5) ? 12'(vec2[i]) : 12'sd0;
      #1;
      if (sat1) satcnt++;
      if (ov1 && r1) got.push_back(o1);
      cyc();
    end
    check("t2_count", got.size(), 5);
    for (int j = 0; j < 5; j++) check($sformatf("t2_out%0d", j), qget(j), exp2[j]);
    check("t2_no_sat", satcnt, 0);

    // 3. Saturation: positive clamps with a pulse, most negative fits exactly
    v1 = 1'b1; d1 = 12'sd2047;
    #1; cyc();
    v1 = 1'b1; d1 = -12'sd2048;
    #1;
    check("t3_sat_pulse", sat1, 1);
    cyc();
    v1 = 1'b0; d1 = 12'sd0;
    #1;
    check("t3_sat_neg_none", sat1, 0);
    check("t3_valid_pos", ov1, 1);
    check("t3_out_pos", o1, 511);
    cyc();
    #1;
    check("t3_sat_after", sat1, 0);
    check("t3_valid_neg", ov1, 1);
    check("t3_out_neg", o1, -512);
    cyc();
    #1;
    check("t3_drained", ov1, 0);

    // 4. Backpressure: six samples into a four-entry FIFO
    r1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v1 = (i < 6);
      d1 = (i < 6) ? 12'(vec4[i]) : 12'sd0;
      #1;
      if (i == 5) begin
        check("t4_no_sat_on_drop", sat1, 0);
        check("t4_ovf_before_drop", of1, 0);
      end
      if (i == 6) check("t4_ovf_after_drop", of1, 1);
      cyc();
    end
    r1 = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ov1 && r1) got.push_back(o1);
      cyc();
    end
    check("t4_count", got.size(), 4);
    for (int j = 0; j < 4; j++) check($sformatf("t4_out%0d", j), qget(j), exp4[j]);
    check("t4_empty", ov1, 0);
    check("t4_ovf_sticky", of1, 1);

    // 5. Fill, then stream with simultaneous push and pop while full
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    #1;
    check("t5_rst_clears_ovf", of1, 0);
    got.delete();
    for (int i = 0; i < 18; i++) begin
      v1 = (i < 10);
      d1 = 12'(100 + 8 * i);
      r1 = (i >= 5);
      #1;
      if (i == 5) check("t5_full_valid", ov1, 1);
      if (ov1 && r1) got.push_back(o1);
      cyc();
    end
    check("t5_count", got.size(), 10);
    for (int j = 0; j < 10; j++) check($sformatf("t5_out%0d", j), qget(j), 25 + 2 * j);
    check("t5_no_ovf", of1, 0);
    check("t5_empty", ov1, 0);

    // 6. Reset mid-stream with two entries queued and phase=2 (DECIM=4)
    r4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v4 = (i < 6);
      d4 = (i < 6) ? 12'(vec6[i]) : 12'sd0;
      #1; cyc();
    end
    #1;
    check("t6_queued", ov4, 1);
    rst4 = 1'b1; v4 = 1'b0;
    cyc();
    rst4 = 1'b0;
    #1;
    check("t6_rst_valid", ov4, 0);
    check("t6_rst_ovf", of4, 0);
    v4 = 1'b1; d4 = 12'sd60; r4 = 1'b1;
    #1; cyc();
    v4 = 1'b0; d4 = 12'sd0;
    #1;
    check("t6_lat_t1", ov4, 0);
    cyc();
    #1;
    check("t6_kept_valid", ov4, 1);
    check("t6_kept_data", o4, 15);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
